port_input_conditioner: RTL and testbench
=========================================

PORT_INPUT_CONDITIONER -- requirements
Module: port_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive mismatching clock edges needed to accept a new pin level; legal range 1..255.
REQ-002 SHALL have parameter WIDTH, default 4, meaning number of input pins conditioned; the system instance uses 4, matching the CPU port_input.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_raw  input  WIDTH  asynchronous pin levels from the board.
REQ-006 SHALL have port in_evt_clr  input  WIDTH  per-bit clear mask for out_evt.
REQ-007 SHALL have port out_port  output  WIDTH  debounced stable levels; drives the CPU port_input.
REQ-008 SHALL have port out_change  output  WIDTH  one-cycle pulse per bit when out_port flips.
REQ-009 SHALL have port out_evt  output  WIDTH  sticky per-bit change flags.

Function
REQ-010 SHALL pass each in_raw bit through a two-flop synchronizer (sync1, then sync2); only sync2 feeds later logic.
REQ-011 SHALL keep one counter per bit, width ceil(log2(DEBOUNCE_CYCLES+1)), saturating, never wrapping.
REQ-012 SHALL handle each bit per edge as a two-state FSM: STABLE (sync2 == out_port) and PENDING (sync2 != out_port).
REQ-013 SHALL, in STABLE, hold the counter at 0.
REQ-014 SHALL, in PENDING with counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-015 SHALL, in PENDING with counter == DEBOUNCE_CYCLES-1, load out_port[i] <= sync2[i] and clear the counter (flip on the DEBOUNCE_CYCLES-th consecutive mismatch edge).
REQ-016 SHALL return to STABLE with the counter cleared when sync2 matches out_port again before the flip; a glitch shorter than DEBOUNCE_CYCLES edges never reaches out_port.
REQ-017 SHALL give a latency of exactly 2+DEBOUNCE_CYCLES edges from a clean in_raw transition (set up before edge 1) to the out_port flip (at edge 2+DEBOUNCE_CYCLES); with DEBOUNCE_CYCLES=1 that is edge 3.
REQ-018 SHALL register out_change[i]: high for exactly the one cycle following the edge on which out_port[i] flips, low otherwise.
REQ-019 SHALL set out_evt[i] on the flip edge of bit i and clear it on an edge where in_evt_clr[i]=1 and no flip occurs.
REQ-020 SHALL give set priority over clear when a flip and in_evt_clr[i] coincide on the same edge, so no event is lost.
REQ-021 SHALL process bits fully independently; simultaneous flips on several bits all report in the same cycle.
REQ-022 SHALL drive all outputs directly from flops, with no combinational path from in_raw or in_evt_clr to any output.

Reset
REQ-023 SHALL, on any edge with rst=1, clear sync1, sync2, all counters, out_port, out_change and out_evt to 0; rst has priority over all other inputs.
REQ-024 SHALL, after rst is asserted mid-PENDING, discard the partial count; after release a still-high pin requires the full 2+DEBOUNCE_CYCLES edges to appear.
REQ-025 SHALL NOT generate out_change or out_evt from the reset-to-0 transition itself.

Verification
REQ-026 SHALL cover clean edge: DEBOUNCE_CYCLES=4, in_raw 0000->0001 before edge 1 -> out_port=0001 after edge 6, out_change=0001 for one cycle, out_evt=0001 held.
REQ-027 SHALL cover glitch rejection: in_raw bit2 high for 3 cycles then low -> out_port, out_change and out_evt stay 0000.
REQ-028 SHALL cover clear versus set: out_evt=0001, in_evt_clr=0001 held across a bit0 1->0 flip edge -> out_evt[0]=1 after that edge, then 0 on the next edge with the clear still held.
REQ-029 SHALL cover simultaneous flips: in_raw 0000->1010 -> out_port=1010 and out_change=1010 in the same cycle, edge 6.
REQ-030 SHALL cover reset mid-pending: in_raw=1111, rst pulsed at edge 4 -> all outputs 0 after edge 4; out_port=1111 after edge 10.
REQ-031 SHALL cover minimum debounce: DEBOUNCE_CYCLES=1, in_raw 0000->0100 -> out_port=0100 after edge 3; a one-cycle pulse >= 1 edge at sync2 is accepted.

Source files
------------

// File: rtl/port_input_conditioner.sv
// -----------------------------------------------------------------------------
// port_input_conditioner
//
// Conditions WIDTH asynchronous board pins for the CPU input port. Each pin is
// brought into the clk domain through a two-flop synchronizer and then
// debounced. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// clock edges on which the synchronized pin disagrees with the accepted level.
// Every accepted flip produces a one-cycle change pulse and sets a sticky
// event flag that software clears per bit.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive mismatching edges needed to flip (1..255)
//   WIDTH            number of pins conditioned
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   rst         in   synchronous active-high reset, overrides all other inputs
//   in_raw      in   asynchronous pin levels from the board
//   in_evt_clr  in   per-bit clear mask for out_evt
//   out_port    out  debounced stable levels
//   out_change  out  one-cycle pulse per bit on the cycle after a flip
//   out_evt     out  sticky per-bit change flags (set beats clear)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module port_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [WIDTH-1:0] in_evt_clr,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_change,
    output logic [WIDTH-1:0] out_evt
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the DEBOUNCE_CYCLES-th mismatching edge flips.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Per-bit debounce state. The state is not stored separately: it is fully
    // determined by whether the synchronized pin agrees with the accepted level.
    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } bit_state_e;

    logic [WIDTH-1:0] sync1_q,  sync1_d;
    logic [WIDTH-1:0] sync2_q,  sync2_d;
    logic [WIDTH-1:0] port_q,   port_d;
    logic [WIDTH-1:0] change_q, change_d;
    logic [WIDTH-1:0] evt_q,    evt_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    bit_state_e       bit_state [WIDTH];
    logic [WIDTH-1:0] flip;

    // NOTE: every signal written here gets a default before any branch, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
        flip    = '0;

        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i]     = cnt_q[i];
            bit_state[i] = (sync2_q[i] == port_q[i]) ? ST_STABLE : ST_PENDING;

            unique case (bit_state[i])
                ST_STABLE: begin
                    // Pin agrees with the accepted level: any partial count
                    // from a glitch is discarded here.
                    cnt_d[i] = '0;
                end
                ST_PENDING: begin
                    if (cnt_q[i] == CNT_LAST) begin
                        flip[i]  = 1'b1;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] < CNT_LAST) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                    // Above CNT_LAST is unreachable; the counter holds there
                    // rather than wrapping.
                end
                default: cnt_d[i] = '0;
            endcase
        end

        port_d   = port_q ^ flip;
        change_d = flip;
        // A flip sets the flag even when a clear is requested on the same edge.
        evt_d    = flip | (evt_q & ~in_evt_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            port_q   <= '0;
            change_q <= '0;
            evt_q    <= '0;
            // NOTE: the counter array is real per-bit state, not a RAM, so it
            // is cleared element by element; otherwise a partial count would
            // survive reset and shorten the next debounce.
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            port_q   <= port_d;
            change_q <= change_d;
            evt_q    <= evt_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_port   = port_q;
    assign out_change = change_q;
    assign out_evt    = evt_q;

endmodule

// File: tb/tb_port_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_port_input_conditioner
//
// Drives two instances (DEBOUNCE_CYCLES = 4 and = 1) with the same stimulus and
// compares every output after every edge against a window-based reference:
// a pin flips on edge e when the synchronized level seen on each of the last
// D edges (all later than the previous flip or reset) differs from the
// accepted level. Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_port_input_conditioner;

    localparam int W     = 4;
    localparam int HIST  = 8192;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_raw;
    logic [W-1:0] in_evt_clr;

    logic [W-1:0] d4_port, d4_chg, d4_evt;
    logic [W-1:0] d1_port, d1_chg, d1_evt;

    port_input_conditioner #(.DEBOUNCE_CYCLES(4), .WIDTH(W)) dut_d4 (
        .clk        (clk),
        .rst        (rst),
        .in_raw     (in_raw),
        .in_evt_clr (in_evt_clr),
        .out_port   (d4_port),
        .out_change (d4_chg),
        .out_evt    (d4_evt)
    );

    port_input_conditioner #(.DEBOUNCE_CYCLES(1), .WIDTH(W)) dut_d1 (
        .clk        (clk),
        .rst        (rst),
        .in_raw     (in_raw),
        .in_evt_clr (in_evt_clr),
        .out_port   (d1_port),
        .out_change (d1_chg),
        .out_evt    (d1_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int           dval [2] = '{4, 1};
    int           edge_no;
    logic [W-1:0] m_s1, m_s2;           // pin levels delayed by one and two edges
    logic [W-1:0] s2_hist [HIST];       // synchronized level seen at each edge
    logic [W-1:0] exp_port [2];
    logic [W-1:0] exp_chg  [2];
    logic [W-1:0] exp_evt  [2];
    int           last_edge [2][W];     // last flip or reset edge per bit

    task automatic model_init();
        edge_no = 0;
        m_s1 = '0;
        m_s2 = '0;
        for (int x = 0; x < 2; x++) begin
            exp_port[x] = '0;
            exp_chg[x]  = '0;
            exp_evt[x]  = '0;
            for (int b = 0; b < W; b++) last_edge[x][b] = 0;
        end
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now set.
    task automatic model_edge();
        logic [W-1:0] seen;
        logic [W-1:0] flips;
        bit           all_differ;
        edge_no++;
        seen = m_s2;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            for (int x = 0; x < 2; x++) begin
                exp_port[x] = '0;
                exp_chg[x]  = '0;
                exp_evt[x]  = '0;
                for (int b = 0; b < W; b++) last_edge[x][b] = edge_no;
            end
        end else begin
            s2_hist[edge_no % HIST] = seen;
            m_s2 = m_s1;
            m_s1 = in_raw;
            for (int x = 0; x < 2; x++) begin
                flips = '0;
                for (int b = 0; b < W; b++) begin
                    if (edge_no - last_edge[x][b] >= dval[x]) begin
                        all_differ = 1'b1;
                        for (int k = 0; k < dval[x]; k++)
                            if (s2_hist[(edge_no - k) % HIST][b] == exp_port[x][b])
                                all_differ = 1'b0;
                        if (all_differ) begin
                            flips[b] = 1'b1;
                            last_edge[x][b] = edge_no;
                        end
                    end
                end
                exp_port[x] = exp_port[x] ^ flips;
                exp_chg[x]  = flips;
                exp_evt[x]  = flips | (exp_evt[x] & ~in_evt_clr);
            end
        end
    endtask

    task automatic compare_all();
        check("d4.out_port",   d4_port, exp_port[0]);
        check("d4.out_change", d4_chg,  exp_chg[0]);
        check("d4.out_evt",    d4_evt,  exp_evt[0]);
        check("d1.out_port",   d1_port, exp_port[1]);
        check("d1.out_change", d1_chg,  exp_chg[1]);
        check("d1.out_evt",    d1_evt,  exp_evt[1]);
    endtask

    // Called at a falling edge: apply inputs, predict, cross the rising edge,
    // then compare at the next falling edge.
    task automatic cycle(input logic r, input logic [W-1:0] raw, input logic [W-1:0] clr);
        rst        = r;
        in_raw     = raw;
        in_evt_clr = clr;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] raw;
        logic [W-1:0] clr;
        logic         r;

        rst        = 1'b1;
        in_raw     = '0;
        in_evt_clr = '0;
        model_init();
        @(negedge clk);

        // Reset state
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("reset out_port",   d4_port, 4'b0000);
        check("reset out_change", d4_chg,  4'b0000);
        check("reset out_evt",    d4_evt,  4'b0000);
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000);

        // Clean edge on bit 0: flip at edge 6
        for (int e = 1; e <= 7; e++) begin
            cycle(1'b0, 4'b0001, 4'b0000);
            if (e == 3) check("d1 clean flip edge3", d1_port, 4'b0001);
            if (e == 5) check("clean edge5 port", d4_port, 4'b0000);
            if (e == 6) begin
                check("clean edge6 port",   d4_port, 4'b0001);
                check("clean edge6 change", d4_chg,  4'b0001);
            end
            if (e == 7) begin
                check("clean edge7 change", d4_chg, 4'b0000);
                check("clean edge7 evt",    d4_evt, 4'b0001);
            end
        end

        // Clear held across the 1->0 flip edge: set wins, then clear applies
        for (int e = 1; e <= 7; e++) begin
            cycle(1'b0, 4'b0000, (e >= 6) ? 4'b0001 : 4'b0000);
            if (e == 6) begin
                check("clr-vs-set port", d4_port, 4'b0000);
                check("clr-vs-set evt",  d4_evt,  4'b0001);
            end
            if (e == 7) check("clr-after-set evt", d4_evt, 4'b0000);
        end

        // Glitch on bit 2 for three edges
        cycle(1'b0, 4'b0000, 4'b1111);
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0, (e <= 3) ? 4'b0100 : 4'b0000, 4'b0000);
            check("glitch d4 port",   d4_port, 4'b0000);
            check("glitch d4 change", d4_chg,  4'b0000);
            check("glitch d4 evt",    d4_evt,  4'b0000);
            if (e == 3) check("d1 min debounce edge3", d1_port, 4'b0100);
        end

        // Simultaneous flips on bits 3 and 1
        repeat (2) cycle(1'b0, 4'b0000, 4'b1111);
        for (int e = 1; e <= 7; e++) begin
            cycle(1'b0, 4'b1010, 4'b0000);
            if (e == 5) check("simul edge5 port", d4_port, 4'b0000);
            if (e == 6) begin
                check("simul edge6 port",   d4_port, 4'b1010);
                check("simul edge6 change", d4_chg,  4'b1010);
            end
        end

        // Reset mid-pending from a non-zero state
        for (int e = 1; e <= 11; e++) begin
            cycle((e == 4) ? 1'b1 : 1'b0, 4'b1111, 4'b0000);
            if (e == 4) begin
                check("rst-mid port",   d4_port, 4'b0000);
                check("rst-mid change", d4_chg,  4'b0000);
                check("rst-mid evt",    d4_evt,  4'b0000);
            end
            if (e == 5) begin
                check("post-rst change", d4_chg, 4'b0000);
                check("post-rst evt",    d4_evt, 4'b0000);
            end
            if (e == 9)  check("rst-mid edge9 port",  d4_port, 4'b0000);
            if (e == 10) check("rst-mid edge10 port", d4_port, 4'b1111);
        end

        // Randomized traffic: bursty pins, random clears, rare resets
        raw = in_raw;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(4, 0) == 0) raw[b] = ~raw[b];
            for (int b = 0; b < W; b++)
                clr[b] = ($urandom_range(3, 0) == 0);
            r = ($urandom_range(199, 0) == 0);
            cycle(r, raw, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
